// File: rtl/ni_packetizer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ni_packetizer_pkg
// Purpose  : Shared flit-id codes, header field offsets and packetizer states
// Revision : 1.0 - initial release
// ============================================================================
package ni_packetizer_pkg;

  localparam int FLIT_ID_W = 3;
  localparam int ADDR_W    = 4;
  localparam int SEQ_W     = 12;

  // HEADER must stay identical to the code the router's LBDR stage decodes.
  localparam logic [FLIT_ID_W-1:0] HEADER = 3'b001;
  localparam logic [FLIT_ID_W-1:0] BODY   = 3'b010;
  localparam logic [FLIT_ID_W-1:0] TAIL   = 3'b100;

  localparam int HDR_DST_LSB = 25;
  localparam int HDR_SRC_LSB = 21;
  localparam int HDR_LEN_LSB = 13;
  localparam int HDR_SEQ_LSB = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    ZTAIL   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ni_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : ni_credit_counter
// Purpose  : Tracks free slots in the downstream router input FIFO
// Revision : 1.0 - initial release
// ============================================================================
module ni_credit_counter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             consume,
  input  logic             credit_in,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             has_credit
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0] credit_cnt_q;
  logic [CNT_W-1:0] credit_cnt_d;

  // A return and a spend in the same cycle cancel; returns beyond depth are dropped.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    if (consume && !credit_in) begin
      credit_cnt_d = credit_cnt_q - CNT_W'(1);
    end else if (credit_in && !consume && (credit_cnt_q != FULL)) begin
      credit_cnt_d = credit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt_q <= FULL;
    end else begin
      credit_cnt_q <= credit_cnt_d;
    end
  end

  assign credit_cnt = credit_cnt_q;
  assign has_credit = (credit_cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/ni_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : ni_packetizer
// Purpose  : NI transmit side, builds HEADER/BODY/TAIL flits with credit flow
//            control. NI_PARITY_EN adds flit_parity and skips self-addressed
//            packets in pkt_count.
// Revision : 1.0 - initial release
// ============================================================================
module ni_packetizer
  import ni_packetizer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   cur_addr_rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_dst,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                pl_valid,
  output logic                pl_ready,
  input  logic [DATA_W-4:0]   pl_data,
  output logic [DATA_W-1:0]   flit_out,
  output logic                flit_valid,
`ifdef NI_PARITY_EN
  output logic                flit_parity,
`endif
  input  logic                credit_in,
  output logic                busy,
  output logic [15:0]         pkt_count
);

  localparam int PL_W  = DATA_W - FLIT_ID_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [ADDR_W-1:0]  cur_addr_q;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [15:0]        pkt_count_q, pkt_count_d;
  logic [DATA_W-1:0]  flit_out_q, flit_out_d;
  logic               flit_valid_q, flit_valid_d;
  logic [DATA_W-1:0]  hdr_flit;
  logic               emit;
  logic               done;
  logic               count_en;
  logic [CNT_W-1:0]   credit_cnt;
  logic               has_credit;

  ni_credit_counter #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .consume    (emit),
    .credit_in  (credit_in),
    .credit_cnt (credit_cnt),
    .has_credit (has_credit)
  );

`ifdef NI_PARITY_EN
  assign count_en = (dst_q != cur_addr_q);
`else
  assign count_en = 1'b1;
`endif

  always_comb begin
    hdr_flit = '0;
    hdr_flit[DATA_W-1 -: FLIT_ID_W]     = HEADER;
    hdr_flit[HDR_DST_LSB +: ADDR_W]     = dst_q;
    hdr_flit[HDR_SRC_LSB +: ADDR_W]     = cur_addr_q;
    hdr_flit[HDR_LEN_LSB +: LEN_W]      = len_q;
    hdr_flit[HDR_SEQ_LSB +: SEQ_W]      = seq_q;
  end

  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    len_d       = len_q;
    rem_d       = rem_q;
    seq_d       = seq_q;
    pkt_count_d = pkt_count_q;
    flit_out_d  = flit_out_q;
    emit        = 1'b0;
    done        = 1'b0;
    req_ready   = 1'b0;
    pl_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          dst_d   = req_dst;
          len_d   = req_len;
          state_d = HDR;
        end
      end
      HDR: begin
        if (has_credit) begin
          emit       = 1'b1;
          flit_out_d = hdr_flit;
          if (len_q == '0) begin
            state_d = ZTAIL;
          end else begin
            rem_d   = len_q;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        pl_ready = (credit_cnt != '0);
        if (pl_valid && pl_ready) begin
          emit  = 1'b1;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q > LEN_W'(1)) begin
            flit_out_d = {BODY, pl_data};
          end else begin
            flit_out_d = {TAIL, pl_data};
            done       = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      ZTAIL: begin
        if (has_credit) begin
          emit       = 1'b1;
          flit_out_d = {TAIL, PL_W'(0)};
          done       = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    flit_valid_d = emit;
    if (done) begin
      seq_d = seq_q + SEQ_W'(1);
      if (count_en) begin
        pkt_count_d = pkt_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dst_q        <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      seq_q        <= '0;
      pkt_count_q  <= '0;
      flit_out_q   <= '0;
      flit_valid_q <= 1'b0;
      cur_addr_q   <= cur_addr_rst;
    end else begin
      state_q      <= state_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      seq_q        <= seq_d;
      pkt_count_q  <= pkt_count_d;
      flit_out_q   <= flit_out_d;
      flit_valid_q <= flit_valid_d;
    end
  end

`ifdef NI_PARITY_EN
  logic flit_parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_parity_q <= 1'b0;
    end else if (emit) begin
      flit_parity_q <= ^flit_out_d;
    end
  end

  assign flit_parity = flit_parity_q;
`endif

  assign flit_out   = flit_out_q;
  assign flit_valid = flit_valid_q;
  assign busy       = (state_q != IDLE);
  assign pkt_count  = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ni_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ni_packetizer
// Purpose  : Scoreboard bench for ni_packetizer flit generation and credits
// Revision : 1.0 - initial release
// ============================================================================
module tb_ni_packetizer;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int PL_W   = DATA_W - 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        cur_addr_rst = 4'h5;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_dst = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              pl_valid = 1'b0;
  logic              pl_ready;
  logic [PL_W-1:0]   pl_data = '0;
  logic [DATA_W-1:0] flit_out;
  logic              flit_valid;
  logic              credit_in = 1'b0;
  logic              busy;
  logic [15:0]       pkt_count;
`ifdef NI_PARITY_EN
  logic              flit_parity;
`endif

  always #5 clk = ~clk;

  ni_packetizer #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cur_addr_rst (cur_addr_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dst      (req_dst),
    .req_len      (req_len),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .pl_data      (pl_data),
    .flit_out     (flit_out),
    .flit_valid   (flit_valid),
`ifdef NI_PARITY_EN
    .flit_parity  (flit_parity),
`endif
    .credit_in    (credit_in),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int cred_min;
  logic cred_bad, pl_ready_seen;
  logic rst_drv = 1'b1, credit_drv = 1'b0, pl_fire = 1'b0, req_fire = 1'b0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  int                got_cyc[$];
  logic              got_par[$];
  logic [PL_W-1:0]   pl_src[$];

  function automatic logic [DATA_W-1:0] hdr_f(input logic [3:0] d, input logic [3:0] s,
                                              input logic [7:0] l, input logic [11:0] sq);
    return {3'b001, d, s, l, sq, 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] body_f(input logic [PL_W-1:0] p);
    return {3'b010, p};
  endfunction

  function automatic logic [DATA_W-1:0] tail_f(input logic [PL_W-1:0] p);
    return {3'b100, p};
  endfunction

  // One clock of stimulus: observe outputs at the falling edge, then drive.
  task automatic cycle();
    logic [PL_W-1:0] drop;
    @(negedge clk);
    cyc++;
    if (flit_valid === 1'b1) begin
      got_q.push_back(flit_out);
      got_cyc.push_back(cyc);
`ifdef NI_PARITY_EN
      got_par.push_back(flit_parity);
`else
      got_par.push_back(1'b0);
`endif
    end
    if (int'(dut.credit_cnt) > 4) cred_bad = 1'b1;
    if (int'(dut.credit_cnt) < cred_min) cred_min = int'(dut.credit_cnt);
    if (pl_ready === 1'b1) pl_ready_seen = 1'b1;
    if (pl_fire) drop = pl_src.pop_front();
    if (req_fire) req_valid = 1'b0;
    rst       = rst_drv;
    credit_in = credit_drv;
    pl_valid  = (pl_src.size() > 0);
    pl_data   = pl_valid ? pl_src[0] : '0;
    pl_fire   = pl_valid && pl_ready && !rst;
    req_fire  = req_valid && req_ready && !rst;
  endtask

  task automatic start_req(input logic [3:0] d, input logic [7:0] l);
    req_valid = 1'b1;
    req_dst   = d;
    req_len   = l;
    req_fire  = req_ready && !rst;
  endtask

  task automatic clear_obs();
    exp_q.delete(); got_q.delete(); got_cyc.delete(); got_par.delete();
    cred_min = 99; cred_bad = 1'b0; pl_ready_seen = 1'b0;
  endtask

  task automatic test_reset();
    clear_obs();
    rst_drv = 1'b1;
    repeat (2) cycle();
    rst_drv = 1'b0;
    cycle();
    checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL rst_flit_valid got %b exp 0", flit_valid); end
    checks++; if (flit_out !== '0) begin errors++; $display("FAIL rst_flit_out got %h exp 0", flit_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if (pl_ready !== 1'b0) begin errors++; $display("FAIL rst_pl_ready got %b exp 0", pl_ready); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt_count got %0d exp 0", pkt_count); end
    checks++; if (int'(dut.credit_cnt) != 4) begin errors++; $display("FAIL rst_credit got %0d exp 4", dut.credit_cnt); end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] g, e;
    clear_obs();
    exp_q.push_back(hdr_f(4'hA, 4'h5, 8'd2, 12'd0));
    exp_q.push_back(body_f(29'h111));
    exp_q.push_back(tail_f(29'h222));
    pl_src.push_back(29'h111); pl_src.push_back(29'h222);
    start_req(4'hA, 8'd2);
    repeat (8) cycle();
    checks++;
    if (got_cyc.size() != 3 || (got_cyc[got_cyc.size()-1] - got_cyc[0]) != 2) begin
      errors++; $display("FAIL basic_consecutive got %0d flits exp 3 in 3 cycles", got_cyc.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL basic_flit got %h exp %h", g, e); end
    end
    checks++; if (int'(dut.credit_cnt) != 1) begin errors++; $display("FAIL basic_credit got %0d exp 1", dut.credit_cnt); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL basic_pkt_count got %0d exp 1", pkt_count); end
    credit_drv = 1'b1; repeat (4) cycle(); credit_drv = 1'b0; cycle();
  endtask

  task automatic test_credit_stall();
    logic [DATA_W-1:0] g, e;
    clear_obs();
    exp_q.push_back(hdr_f(4'h3, 4'h5, 8'd6, 12'd1));
    for (int i = 1; i <= 6; i++) begin
      pl_src.push_back(PL_W'(32'h1000 + i));
      exp_q.push_back(i < 6 ? body_f(PL_W'(32'h1000 + i)) : tail_f(PL_W'(32'h1000 + i)));
    end
    start_req(4'h3, 8'd6);
    repeat (10) cycle();
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL stall_count got %0d exp 4", got_q.size()); end
    checks++; if (pl_ready !== 1'b0) begin errors++; $display("FAIL stall_pl_ready got %b exp 0", pl_ready); end
    checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL stall_flit_valid got %b exp 0", flit_valid); end
    for (int p = 0; p < 2; p++) begin
      credit_drv = 1'b1; cycle(); credit_drv = 1'b0; repeat (3) cycle();
    end
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL stall_after_credit got %0d exp 6", got_q.size()); end
    credit_drv = 1'b1; repeat (8) cycle(); credit_drv = 1'b0; cycle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL stall_flit got %h exp %h", g, e); end
    end
    checks++; if (cred_bad !== 1'b0 || cred_min != 0) begin errors++; $display("FAIL stall_credit_range got min %0d over %b exp min 0 over 0", cred_min, cred_bad); end
    checks++; if (int'(dut.credit_cnt) != 4) begin errors++; $display("FAIL stall_credit_final got %0d exp 4", dut.credit_cnt); end
    checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL stall_pkt_count got %0d exp 2", pkt_count); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] g, e;
    clear_obs();
    credit_drv = 1'b1;
    exp_q.push_back(hdr_f(4'hC, 4'h5, 8'd3, 12'd2));
    exp_q.push_back(body_f(29'hA1)); exp_q.push_back(body_f(29'hA2)); exp_q.push_back(tail_f(29'hA3));
    pl_src.push_back(29'hA1); pl_src.push_back(29'hA2); pl_src.push_back(29'hA3);
    start_req(4'hC, 8'd3);
    repeat (8) cycle();
    credit_drv = 1'b0; cycle();
    checks++;
    if (got_cyc.size() != 4 || (got_cyc[got_cyc.size()-1] - got_cyc[0]) != 3) begin
      errors++; $display("FAIL b2b_consecutive got %0d flits exp 4 in 4 cycles", got_cyc.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_flit got %h exp %h", g, e); end
    end
    checks++; if (cred_min != 4) begin errors++; $display("FAIL b2b_credit_min got %0d exp 4", cred_min); end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL b2b_pkt_count got %0d exp 3", pkt_count); end
  endtask

  task automatic test_zero_len();
    logic [DATA_W-1:0] g, e;
    clear_obs();
    exp_q.push_back(hdr_f(4'h0, 4'h5, 8'd0, 12'd3));
    exp_q.push_back(tail_f(29'h0));
    start_req(4'h0, 8'd0);
    repeat (6) cycle();
    checks++;
    if (got_cyc.size() != 2 || (got_cyc[got_cyc.size()-1] - got_cyc[0]) != 1) begin
      errors++; $display("FAIL zero_consecutive got %0d flits exp 2 in 2 cycles", got_cyc.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL zero_flit got %h exp %h", g, e); end
    end
    checks++; if (pl_ready_seen !== 1'b0) begin errors++; $display("FAIL zero_pl_ready got %b exp 0", pl_ready_seen); end
    checks++; if (pkt_count !== 16'd4) begin errors++; $display("FAIL zero_pkt_count got %0d exp 4", pkt_count); end
    credit_drv = 1'b1; repeat (3) cycle(); credit_drv = 1'b0; cycle();
  endtask

  task automatic test_reset_mid_packet();
    logic [DATA_W-1:0] g, e;
    clear_obs();
    exp_q.push_back(hdr_f(4'h9, 4'h5, 8'd4, 12'd4));
    exp_q.push_back(body_f(29'hB1)); exp_q.push_back(body_f(29'hB2));
    for (int i = 1; i <= 4; i++) pl_src.push_back(PL_W'(32'hB0 + i));
    start_req(4'h9, 8'd4);
    for (int i = 0; i < 12 && got_q.size() < 3; i++) cycle();
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL midrst_reach got %0d flits exp 3", got_q.size()); end
    rst = 1'b1; pl_fire = 1'b0; req_fire = 1'b0;
    pl_src.delete(); pl_valid = 1'b0;
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL midrst_flit_valid got %b exp 0", flit_valid); end
    checks++; if (int'(dut.credit_cnt) != 4) begin errors++; $display("FAIL midrst_credit got %0d exp 4", dut.credit_cnt); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL midrst_pkt_count got %0d exp 0", pkt_count); end
    repeat (3) cycle();
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL midrst_no_tail got %0d flits exp 3", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL midrst_flit got %h exp %h", g, e); end
    end
    clear_obs();
    exp_q.push_back(hdr_f(4'h6, 4'h5, 8'd1, 12'd0));
    exp_q.push_back(tail_f(29'h77));
    pl_src.push_back(29'h77);
    start_req(4'h6, 8'd1);
    repeat (8) cycle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL postrst_flit got %h exp %h", g, e); end
    end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL postrst_pkt_count got %0d exp 1", pkt_count); end
    credit_drv = 1'b1; repeat (3) cycle(); credit_drv = 1'b0; cycle();
  endtask

  task automatic test_parity_self_addr();
    logic [DATA_W-1:0] g, e;
    logic [15:0]       exp_pkt;
    clear_obs();
    exp_q.push_back(hdr_f(4'h5, 4'h5, 8'd1, 12'd1)); exp_q.push_back(tail_f(29'h1ABCDEF));
    exp_q.push_back(hdr_f(4'h2, 4'h5, 8'd1, 12'd2)); exp_q.push_back(tail_f(29'h0F0F0F0));
    pl_src.push_back(29'h1ABCDEF); pl_src.push_back(29'h0F0F0F0);
    start_req(4'h5, 8'd1);
    repeat (6) cycle();
    start_req(4'h2, 8'd1);
    repeat (6) cycle();
`ifdef NI_PARITY_EN
    exp_pkt = 16'd2;
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_par[i] !== ^got_q[i]) begin errors++; $display("FAIL parity flit%0d got %b exp %b", i, got_par[i], ^got_q[i]); end
    end
`else
    exp_pkt = 16'd3;
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL selfaddr_flit got %h exp %h", g, e); end
    end
    checks++; if (pkt_count !== exp_pkt) begin errors++; $display("FAIL selfaddr_pkt_count got %0d exp %0d", pkt_count, exp_pkt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_back_to_back();
    test_zero_len();
    test_reset_mid_packet();
    test_parity_self_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
